noc_system: RTL and testbench

- Single-input, eight-output flit distribution network (one injection port "stab", eight ejection ports "flee0".."flee7").
- Wormhole-routes packets from the injection port to any subset of the eight ejection ports (multicast by destination bitmask).
- Sits between the packet source and eight consumer tiles.
- Each ejection port is decoupled by its own small output FIFO.

---
 rtl/noc_system.sv | 209 ++++++++++++++++++++
 tb/tb_noc_system.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_system.sv
// noc_system: one injection port wormhole-routed to eight ejection ports.
// Head/single flits carry a destination bitmask in data[7:0]; each ejection
// port is decoupled by its own small FIFO. Multicast writes are all-or-none.

// Per-port ejection FIFO; the output shows the head entry, or zero when empty.
module noc_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          valid_o,
    output logic          full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty;
    logic          do_rd;
    logic          do_wr;

    assign empty     = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign valid_o   = !empty;
    assign rd_data_o = empty ? '0 : mem_q[rptr_q];
    assign do_rd     = rd_en_i && !empty;
    // A write into a full FIFO only lands when the same-edge read frees a slot.
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr) wptr_d = wptr_q + AW'(1);
        if (do_rd) rptr_d = rptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are masked by the empty flag so need no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end
endmodule

module noc_system #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_i_stab,
    input  logic          valid_i_stab,
    output logic          ready_o_stab,
    output logic [DW-1:0] data_o_flee0,
    output logic [DW-1:0] data_o_flee1,
    output logic [DW-1:0] data_o_flee2,
    output logic [DW-1:0] data_o_flee3,
    output logic [DW-1:0] data_o_flee4,
    output logic [DW-1:0] data_o_flee5,
    output logic [DW-1:0] data_o_flee6,
    output logic [DW-1:0] data_o_flee7,
    output logic          valid_o_flee0,
    output logic          valid_o_flee1,
    output logic          valid_o_flee2,
    output logic          valid_o_flee3,
    output logic          valid_o_flee4,
    output logic          valid_o_flee5,
    output logic          valid_o_flee6,
    output logic          valid_o_flee7,
    input  logic          ready_i_flee0,
    input  logic          ready_i_flee1,
    input  logic          ready_i_flee2,
    input  logic          ready_i_flee3,
    input  logic          ready_i_flee4,
    input  logic          ready_i_flee5,
    input  logic          ready_i_flee6,
    input  logic          ready_i_flee7
);
    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_t;

    state_t        state_q, state_d;
    logic [7:0]    mask_q, mask_d;
    flit_t         ftype;
    logic [7:0]    eff_mask;
    logic [7:0]    fifo_full;
    logic [7:0]    fifo_valid;
    logic [7:0]    port_ready;
    logic [7:0]    wr_en;
    logic          accept;
    logic [DW-1:0] fifo_data [8];

    assign ftype      = flit_t'(data_i_stab[DW-1:DW-2]);
    assign port_ready = {ready_i_flee7, ready_i_flee6, ready_i_flee5, ready_i_flee4,
                         ready_i_flee3, ready_i_flee2, ready_i_flee1, ready_i_flee0};

    // Destination set of the flit on the input; zero means drop.
    always_comb begin
        eff_mask = '0;
        if (ftype == FT_HEAD || ftype == FT_SINGLE) begin
            eff_mask = data_i_stab[7:0];
        end else if (state_q == IN_PKT) begin
            eff_mask = mask_q;
        end
    end

    // Accept only when every selected FIFO has room, so multicast is all-or-none.
    assign ready_o_stab = !rst && ((eff_mask & fifo_full) == '0);
    assign accept       = valid_i_stab && ready_o_stab;
    assign wr_en        = accept ? eff_mask : '0;

    // Packet tracking: head opens a packet, tail/single close it, body keeps it.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (accept) begin
            case (ftype)
                FT_HEAD: begin
                    state_d = IN_PKT;
                    mask_d  = data_i_stab[7:0];
                end
                FT_TAIL, FT_SINGLE: begin
                    state_d = IDLE;
                    mask_d  = '0;
                end
                default: ;
            endcase
        end
    end

    // Router state and latched packet mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_port
        noc_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[k]),
            .wr_data_i (data_i_stab),
            .rd_en_i   (port_ready[k]),
            .rd_data_o (fifo_data[k]),
            .valid_o   (fifo_valid[k]),
            .full_o    (fifo_full[k])
        );
    end

    assign data_o_flee0  = fifo_data[0];
    assign data_o_flee1  = fifo_data[1];
    assign data_o_flee2  = fifo_data[2];
    assign data_o_flee3  = fifo_data[3];
    assign data_o_flee4  = fifo_data[4];
    assign data_o_flee5  = fifo_data[5];
    assign data_o_flee6  = fifo_data[6];
    assign data_o_flee7  = fifo_data[7];
    assign valid_o_flee0 = fifo_valid[0];
    assign valid_o_flee1 = fifo_valid[1];
    assign valid_o_flee2 = fifo_valid[2];
    assign valid_o_flee3 = fifo_valid[3];
    assign valid_o_flee4 = fifo_valid[4];
    assign valid_o_flee5 = fifo_valid[5];
    assign valid_o_flee6 = fifo_valid[6];
    assign valid_o_flee7 = fifo_valid[7];
endmodule

// File: tb/tb_noc_system.sv
// Self-checking bench for noc_system: directed scenarios plus random traffic,
// compared against a queue-based reference model of the distribution network.
module tb_noc_system;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          vin;
    logic          rdy_o;
    logic [DW-1:0] dout [8];
    logic          vout [8];
    logic          rdy  [8];

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per port plus packet-open flag and mask.
    logic [DW-1:0] mq [8][$];
    bit            m_inpkt;
    logic [7:0]    m_mask;

    always #5 clk = ~clk;

    noc_system #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i_stab   (din),
        .valid_i_stab  (vin),
        .ready_o_stab  (rdy_o),
        .data_o_flee0  (dout[0]),
        .data_o_flee1  (dout[1]),
        .data_o_flee2  (dout[2]),
        .data_o_flee3  (dout[3]),
        .data_o_flee4  (dout[4]),
        .data_o_flee5  (dout[5]),
        .data_o_flee6  (dout[6]),
        .data_o_flee7  (dout[7]),
        .valid_o_flee0 (vout[0]),
        .valid_o_flee1 (vout[1]),
        .valid_o_flee2 (vout[2]),
        .valid_o_flee3 (vout[3]),
        .valid_o_flee4 (vout[4]),
        .valid_o_flee5 (vout[5]),
        .valid_o_flee6 (vout[6]),
        .valid_o_flee7 (vout[7]),
        .ready_i_flee0 (rdy[0]),
        .ready_i_flee1 (rdy[1]),
        .ready_i_flee2 (rdy[2]),
        .ready_i_flee3 (rdy[3]),
        .ready_i_flee4 (rdy[4]),
        .ready_i_flee5 (rdy[5]),
        .ready_i_flee6 (rdy[6]),
        .ready_i_flee7 (rdy[7])
    );

    function automatic logic [7:0] m_eff(input logic [DW-1:0] d);
        logic [1:0] t;
        t = d[DW-1:DW-2];
        if (t == 2'b01 || t == 2'b11) return d[7:0];
        return m_inpkt ? m_mask : 8'h00;
    endfunction

    function automatic bit m_ready();
        logic [7:0] e;
        if (rst) return 1'b0;
        e = m_eff(din);
        for (int k = 0; k < 8; k++)
            if (e[k] && mq[k].size() >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] m_head(input int k);
        if (mq[k].size() == 0) return '0;
        return mq[k][0];
    endfunction

    // Advance model by one clock using the current inputs, then step the DUT.
    task automatic tick();
        bit         acc;
        logic [7:0] e;
        logic [1:0] t;
        acc = vin && m_ready();
        e   = m_eff(din);
        t   = din[DW-1:DW-2];
        if (rst) begin
            for (int k = 0; k < 8; k++) mq[k].delete();
            m_inpkt = 1'b0;
            m_mask  = 8'h00;
        end else begin
            for (int k = 0; k < 8; k++)
                if (rdy[k] && mq[k].size() != 0) void'(mq[k].pop_front());
            if (acc) begin
                for (int k = 0; k < 8; k++)
                    if (e[k]) mq[k].push_back(din);
                if (t == 2'b01) begin
                    m_inpkt = 1'b1;
                    m_mask  = din[7:0];
                end else if (t != 2'b00) begin
                    m_inpkt = 1'b0;
                    m_mask  = 8'h00;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; din = '0;
        for (int k = 0; k < 8; k++) rdy[k] = 1'b1;
        tick();
        tick();
        #1;
        tests++;
        if (rdy_o !== 1'b0) begin
            fails++; $display("FAIL reset_ready got %b exp 0", rdy_o);
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (vout[k] !== 1'b0 || dout[k] !== '0) begin
                fails++; $display("FAIL reset_port%0d got v=%b d=%h exp v=0 d=0", k, vout[k], dout[k]);
            end
        end
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (rdy_o !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready got %b exp 1", rdy_o);
        end
        tick();
        tests++;
        if (rdy_o !== 1'b1 || vout[0] !== 1'b0) begin
            fails++; $display("FAIL post_reset got ready=%b v0=%b exp ready=1 v0=0", rdy_o, vout[0]);
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 3; c++) begin
            vin = (c == 0);
            din = (c == 0) ? 32'hC000_0005 : '0;
            #1;
            tests++;
            if (rdy_o !== m_ready()) begin
                fails++; $display("FAIL single_ready c%0d got %b exp %b", c, rdy_o, m_ready());
            end
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (vout[k] !== (c == 1 && (k == 0 || k == 2)) ||
                    dout[k] !== ((c == 1 && (k == 0 || k == 2)) ? 32'hC000_0005 : 32'h0)) begin
                    fails++; $display("FAIL single_port%0d c%0d got v=%b d=%h exp v=%b d=%h", k, c,
                                      vout[k], dout[k], mq[k].size() != 0, m_head(k));
                end
            end
            tick();
        end
    endtask

    task automatic test_packet();
        logic [DW-1:0] pk [4];
        pk[0] = 32'h4000_0080; pk[1] = 32'h0000_0001;
        pk[2] = 32'h0000_0002; pk[3] = 32'h8000_0003;
        for (int c = 0; c < 6; c++) begin
            vin = (c < 4);
            din = (c < 4) ? pk[c] : '0;
            #1;
            tests++;
            if (rdy_o !== 1'b1) begin
                fails++; $display("FAIL packet_ready c%0d got %b exp 1", c, rdy_o);
            end
            tests++;
            if (c >= 1 && c <= 4) begin
                if (vout[7] !== 1'b1 || dout[7] !== pk[c-1]) begin
                    fails++; $display("FAIL packet_flee7 c%0d got v=%b d=%h exp v=1 d=%h", c, vout[7], dout[7], pk[c-1]);
                end
            end else if (vout[7] !== 1'b0 || dout[7] !== '0) begin
                fails++; $display("FAIL packet_flee7 c%0d got v=%b d=%h exp v=0 d=0", c, vout[7], dout[7]);
            end
            for (int k = 0; k < 7; k++) begin
                tests++;
                if (vout[k] !== 1'b0) begin
                    fails++; $display("FAIL packet_quiet%0d c%0d got v=%b exp 0", k, c, vout[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_f [6];
        logic [DW-1:0] got [$];
        int            sent = 0;
        for (int i = 0; i < 6; i++) exp_f[i] = {2'b11, 14'($urandom), 8'(i), 8'h08};
        rdy[3] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) begin
                tests++;
                if (sent != 4 || rdy_o !== 1'b0) begin
                    fails++; $display("FAIL bp_stall got sent=%0d ready=%b exp sent=4 ready=0", sent, rdy_o);
                end
                rdy[3] = 1'b1;
            end
            vin = (sent < 6);
            din = (sent < 6) ? exp_f[sent] : '0;
            #1;
            tests++;
            if (rdy_o !== m_ready()) begin
                fails++; $display("FAIL bp_ready c%0d got %b exp %b", c, rdy_o, m_ready());
            end
            tests++;
            if (vout[3] !== (mq[3].size() != 0) || dout[3] !== m_head(3)) begin
                fails++; $display("FAIL bp_flee3 c%0d got v=%b d=%h exp v=%b d=%h", c, vout[3], dout[3],
                                  mq[3].size() != 0, m_head(3));
            end
            if (vout[3] && rdy[3]) got.push_back(dout[3]);
            if (vin && m_ready()) sent++;
            tick();
        end
        tests++;
        if (got.size() != 6) begin
            fails++; $display("FAIL bp_count got %0d exp 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== exp_f[i]) begin
                fails++; $display("FAIL bp_order[%0d] got %h exp %h", i, got[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_atomic();
        int acc = 0;
        int pops0 = 0;
        rdy[0] = 1'b1; rdy[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vin = (c < 9);
            din = (c == 0) ? 32'h4000_0003 : {2'b00, 22'($urandom), 8'h00};
            #1;
            tests++;
            if (rdy_o !== m_ready()) begin
                fails++; $display("FAIL atomic_ready c%0d got %b exp %b", c, rdy_o, m_ready());
            end
            tests++;
            if (vout[0] !== (mq[0].size() != 0) || dout[0] !== m_head(0)) begin
                fails++; $display("FAIL atomic_flee0 c%0d got v=%b d=%h exp v=%b d=%h", c, vout[0], dout[0],
                                  mq[0].size() != 0, m_head(0));
            end
            if (c == 8) begin
                tests++;
                if (rdy_o !== 1'b0) begin
                    fails++; $display("FAIL atomic_full_ready got %b exp 0", rdy_o);
                end
            end
            if (vout[0] && rdy[0]) pops0++;
            if (vin && m_ready()) acc++;
            tick();
        end
        tests++;
        if (acc != DEPTH || pops0 != acc) begin
            fails++; $display("FAIL atomic_count got acc=%0d flee0=%0d exp acc=%0d flee0=%0d", acc, pops0, DEPTH, DEPTH);
        end
        rdy[1] = 1'b1;
        vin = 1'b1; din = 32'h8000_0000;
        tick();
        vin = 1'b0; din = '0;
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_drop();
        logic [DW-1:0] seq [7];
        logic          r   [7];
        seq[0] = 32'h4000_0000; seq[1] = 32'h8000_0000; seq[2] = 32'h0000_0055;
        seq[3] = 32'h4000_0010; seq[4] = 32'h0000_0011; seq[5] = 32'h0000_0077; seq[6] = '0;
        r[0] = 0; r[1] = 0; r[2] = 0; r[3] = 0; r[4] = 1; r[5] = 0; r[6] = 0;
        for (int c = 0; c < 7; c++) begin
            rst = r[c];
            vin = (c < 6);
            din = seq[c];
            #1;
            tests++;
            if (rdy_o !== !r[c]) begin
                fails++; $display("FAIL drop_ready c%0d got %b exp %b", c, rdy_o, !r[c]);
            end
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (vout[k] !== (mq[k].size() != 0) || dout[k] !== m_head(k)) begin
                    fails++; $display("FAIL drop_port%0d c%0d got v=%b d=%h exp v=%b d=%h", k, c, vout[k], dout[k],
                                      mq[k].size() != 0, m_head(k));
                end
            end
            if (c <= 3 || c == 6) begin
                tests++;
                if (vout[0] !== 1'b0 || vout[4] !== 1'b0) begin
                    fails++; $display("FAIL drop_quiet c%0d got v0=%b v4=%b exp 0 0", c, vout[0], vout[4]);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] t;
        logic [7:0] m;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 8; k++) rdy[k] = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            vin = $urandom_range(0, 1);
            t   = 2'($urandom);
            m   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            din = {t, 22'($urandom), m};
            #1;
            tests++;
            if (rdy_o !== m_ready()) begin
                fails++; $display("FAIL rnd_ready c%0d got %b exp %b", c, rdy_o, m_ready());
            end
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (vout[k] !== (mq[k].size() != 0) || dout[k] !== m_head(k)) begin
                    fails++; $display("FAIL rnd_port%0d c%0d got v=%b d=%h exp v=%b d=%h", k, c, vout[k], dout[k],
                                      mq[k].size() != 0, m_head(k));
                end
            end
            tick();
        end
        rst = 1'b0; vin = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; din = '0;
        for (int k = 0; k < 8; k++) rdy[k] = 1'b1;
        m_inpkt = 1'b0; m_mask = 8'h00;
        test_reset();
        test_single();
        test_packet();
        test_backpressure();
        test_atomic();
        test_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
